// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
//
// Multi-cycle fetch/decode/execute sequencer for the 8-bit datapath
// (PC, IR, Add_R, Reg_Y, Reg_Z, GPRF R0-R3, ALU, Mux_1, Mux_2).
//
// The FSM sequences each instruction through these states:
//   FETCH0 -> FETCH1 -> DECODE -> (EXEC1 | OPA -> OPB [-> EXEC2] | HALT)
//
// Control outputs are a combinational decode of the registered state, the IR
// contents and the Reg_Z flags. While rst is high, every output is forced to 0.
//
// Ports
//   clk             in   system clock, rising edge
//   rst             in   asynchronous active-high reset
//   ir_out[7:0]     in   IR contents: opcode=[7:4], rs=[3:2], rd=[1:0]
//   flags[7:0]      in   Reg_Z contents, bit 0 = Z
//   load_R0..R3     out  GPRF write enables, one-hot on rd
//   gprf_sel_read   out  GPRF read select
//   gprf_sel_write  out  GPRF write select (rd)
//   inc_PC/load_PC  out  PC increment / load (mutually exclusive)
//   load_Add_R, load_Reg_Y, load_Reg_Z, load_IR  out  register loads
//   alu_select[2:0] out  ALU op: ADD 0, SUB 1, AND 2, OR 3, XOR 4
//   Mux_1_sel[2:0]  out  Bus_1 source (0 gprf ... 5 pc, 6 ir, 7 sp)
//   Mux_2_sel[1:0]  out  Bus_2 source (0 alu, 1 Bus_1, 2 data_ram, 3 zero)
//   halted          out  high in HALT state
//   o_dbg_state     out  current FSM state, for observation only
// -----------------------------------------------------------------------------
module control_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ir_out,
    input  logic [7:0] flags,
    output logic       load_R0,
    output logic       load_R1,
    output logic       load_R2,
    output logic       load_R3,
    output logic [1:0] gprf_sel_read,
    output logic [1:0] gprf_sel_write,
    output logic       inc_PC,
    output logic       load_PC,
    output logic       load_Add_R,
    output logic       load_Reg_Y,
    output logic       load_Reg_Z,
    output logic       load_IR,
    output logic [2:0] alu_select,
    output logic [2:0] Mux_1_sel,
    output logic [1:0] Mux_2_sel,
    output logic       halted,
    output logic [2:0] o_dbg_state
);

    typedef enum logic [2:0] {
        S_FETCH0 = 3'd0,
        S_FETCH1 = 3'd1,
        S_DECODE = 3'd2,
        S_OPA    = 3'd3,
        S_OPB    = 3'd4,
        S_EXEC1  = 3'd5,
        S_EXEC2  = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_MOV = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_XOR = 4'h7;
    localparam logic [3:0] OP_LD  = 4'h8;
    localparam logic [3:0] OP_JMP = 4'h9;
    localparam logic [3:0] OP_JZ  = 4'hA;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [2:0] M1_GPRF = 3'd0;
    localparam logic [2:0] M1_PC   = 3'd5;

    localparam logic [1:0] M2_ALU  = 2'd0;
    localparam logic [1:0] M2_BUS1 = 2'd1;
    localparam logic [1:0] M2_RAM  = 2'd2;

    state_t r_state;
    state_t w_next;

    logic [3:0] w_opcode;
    logic [1:0] w_rs;
    logic [1:0] w_rd;
    logic       w_z;
    logic [3:0] w_load_r;   // one-hot write request, expanded onto rd
    logic       w_wr_gprf;  // a GPRF write is requested this state
    logic       w_unused_flags;

    assign w_opcode       = ir_out[7:4];
    assign w_rs           = ir_out[3:2];
    assign w_rd           = ir_out[1:0];
    assign w_z            = flags[0];
    assign w_unused_flags = ^flags[7:1];

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH0;
        end else begin
            r_state <= w_next;
        end
    end

    assign o_dbg_state = r_state;

    // -------------------------------------------------------------------------
    // Next-state and control decode
    // -------------------------------------------------------------------------
    always_comb begin
        w_next         = r_state;
        w_wr_gprf      = 1'b0;
        gprf_sel_read  = 2'd0;
        gprf_sel_write = w_rd;
        inc_PC         = 1'b0;
        load_PC        = 1'b0;
        load_Add_R     = 1'b0;
        load_Reg_Y     = 1'b0;
        load_Reg_Z     = 1'b0;
        load_IR        = 1'b0;
        alu_select     = 3'd0;
        Mux_1_sel      = 3'd0;
        Mux_2_sel      = 2'd0;
        halted         = 1'b0;

        unique case (r_state)
            S_FETCH0: begin
                // Add_R <= PC via Bus_1
                Mux_1_sel  = M1_PC;
                Mux_2_sel  = M2_BUS1;
                load_Add_R = 1'b1;
                w_next     = S_FETCH1;
            end

            S_FETCH1: begin
                // IR <= RAM[Add_R]; RAM read is asynchronous
                Mux_2_sel = M2_RAM;
                load_IR   = 1'b1;
                inc_PC    = 1'b1;
                w_next    = S_DECODE;
            end

            S_DECODE: begin
                w_next = S_FETCH0;
                case (w_opcode)
                    OP_MOV: begin
                        gprf_sel_read = w_rs;
                        Mux_1_sel     = M1_GPRF;
                        Mux_2_sel     = M2_BUS1;
                        w_wr_gprf     = 1'b1;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                        // Reg_Y takes the old rd so rd==rs still reads R op R
                        gprf_sel_read = w_rd;
                        Mux_1_sel     = M1_GPRF;
                        Mux_2_sel     = M2_BUS1;
                        load_Reg_Y    = 1'b1;
                        w_next        = S_EXEC1;
                    end
                    OP_LDI, OP_LD, OP_JMP, OP_JZ: begin
                        w_next = S_OPA;
                    end
                    OP_HLT: begin
                        w_next = S_HALT;
                    end
                    default: begin
                        // NOP and the undefined opcodes 0xB-0xE
                        w_next = S_FETCH0;
                    end
                endcase
            end

            S_EXEC1: begin
                gprf_sel_read = w_rs;
                Mux_1_sel     = M1_GPRF;
                alu_select    = w_opcode[2:0] - OP_ADD[2:0];
                Mux_2_sel     = M2_ALU;
                w_wr_gprf     = 1'b1;
                load_Reg_Z    = 1'b1;
                w_next        = S_FETCH0;
            end

            S_OPA: begin
                // operand byte lives at the address PC now points to
                Mux_1_sel  = M1_PC;
                Mux_2_sel  = M2_BUS1;
                load_Add_R = 1'b1;
                w_next     = S_OPB;
            end

            S_OPB: begin
                Mux_2_sel = M2_RAM;
                w_next    = S_FETCH0;
                case (w_opcode)
                    OP_LDI: begin
                        w_wr_gprf = 1'b1;
                        inc_PC    = 1'b1;
                    end
                    OP_LD: begin
                        // operand is the data address: Add_R <= RAM[Add_R]
                        load_Add_R = 1'b1;
                        inc_PC     = 1'b1;
                        w_next     = S_EXEC2;
                    end
                    OP_JMP: begin
                        load_PC = 1'b1;
                    end
                    OP_JZ: begin
                        load_PC = w_z;
                        inc_PC  = ~w_z;
                    end
                    default: begin
                        w_next = S_FETCH0;
                    end
                endcase
            end

            S_EXEC2: begin
                Mux_2_sel = M2_RAM;
                w_wr_gprf = 1'b1;
                w_next    = S_FETCH0;
            end

            S_HALT: begin
                gprf_sel_write = 2'd0;
                halted         = 1'b1;
                w_next         = S_HALT;
            end

            default: begin
                w_next = S_FETCH0;
            end
        endcase

        // Reset wins over every decoded control, including FETCH0's
        if (rst) begin
            w_wr_gprf      = 1'b0;
            gprf_sel_read  = 2'd0;
            gprf_sel_write = 2'd0;
            inc_PC         = 1'b0;
            load_PC        = 1'b0;
            load_Add_R     = 1'b0;
            load_Reg_Y     = 1'b0;
            load_Reg_Z     = 1'b0;
            load_IR        = 1'b0;
            alu_select     = 3'd0;
            Mux_1_sel      = 3'd0;
            Mux_2_sel      = 2'd0;
            halted         = 1'b0;
        end
    end

    // GPRF write enable expanded one-hot on rd
    always_comb begin
        w_load_r = 4'b0000;
        if (w_wr_gprf) begin
            w_load_r[w_rd] = 1'b1;
        end
    end

    assign load_R0 = w_load_r[0];
    assign load_R1 = w_load_r[1];
    assign load_R2 = w_load_r[2];
    assign load_R3 = w_load_r[3];

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

  logic       clk;
  logic       rst;
  logic [7:0] ir_out;
  logic [7:0] flags;
  logic       load_R0, load_R1, load_R2, load_R3;
  logic [1:0] gprf_sel_read, gprf_sel_write;
  logic       inc_PC, load_PC, load_Add_R, load_Reg_Y, load_Reg_Z, load_IR;
  logic [2:0] alu_select, Mux_1_sel;
  logic [1:0] Mux_2_sel;
  logic       halted;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;

  logic [22:0] exp_q[$];
  logic [7:0]  pc;

  control_unit dut (
    .clk(clk), .rst(rst), .ir_out(ir_out), .flags(flags),
    .load_R0(load_R0), .load_R1(load_R1), .load_R2(load_R2), .load_R3(load_R3),
    .gprf_sel_read(gprf_sel_read), .gprf_sel_write(gprf_sel_write),
    .inc_PC(inc_PC), .load_PC(load_PC), .load_Add_R(load_Add_R),
    .load_Reg_Y(load_Reg_Y), .load_Reg_Z(load_Reg_Z), .load_IR(load_IR),
    .alu_select(alu_select), .Mux_1_sel(Mux_1_sel), .Mux_2_sel(Mux_2_sel),
    .halted(halted), .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [22:0] obs;
  assign obs = {halted, load_R3, load_R2, load_R1, load_R0,
                gprf_sel_read, gprf_sel_write,
                inc_PC, load_PC, load_Add_R, load_Reg_Y, load_Reg_Z, load_IR,
                alu_select, Mux_1_sel, Mux_2_sel};

  // control word: {halted, load_R[3:0], sel_read, sel_write, inc_PC, load_PC,
  //                load_Add_R, load_Reg_Y, load_Reg_Z, load_IR, alu, m1, m2}
  function automatic logic [22:0] cw(input logic hl, input logic [3:0] ldr,
                                     input logic [1:0] sr, input logic [1:0] sw,
                                     input logic inc, input logic ldpc,
                                     input logic ldadd, input logic ldy,
                                     input logic ldz, input logic ldir,
                                     input logic [2:0] alu, input logic [2:0] m1,
                                     input logic [1:0] m2);
    return {hl, ldr, sr, sw, inc, ldpc, ldadd, ldy, ldz, ldir, alu, m1, m2};
  endfunction

  task automatic check_word(input logic [22:0] e, input string tag);
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  task automatic check_pc(input logic [7:0] e, input string tag);
    checks++;
    assert (pc === e) else begin
      errors++;
      $error("FAIL %s pc observed=%h expected=%h", tag, pc, e);
    end
  endtask

  // Assert reset mid-cycle: outputs must drop at once and stay 0 across an edge.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    check_word('0, {tag, " immediate"});
    @(posedge clk);
    #1;
    check_word('0, {tag, " held"});
    rst = 1'b0;
    pc  = 8'h00;
  endtask

  // driver + scoreboard: push the expected per-cycle controls, then pop one
  // per cycle. The bench PC follows the DUT's inc_PC / load_PC requests, with
  // the operand byte standing in for data_ram during load_PC.
  task automatic run_instr(input logic [7:0] op, input logic [7:0] opnd,
                           input logic [7:0] flg, input int max_cyc,
                           input string tag);
    logic [1:0]  pir_rd, rd, rs;
    logic [3:0]  oh, opc;
    logic [7:0]  exp_pc;
    logic [22:0] e;
    int          total, n;
    pir_rd = ir_out[1:0];
    rd     = op[1:0];
    rs     = op[3:2];
    opc    = op[7:4];
    oh     = 4'b0001 << rd;
    flags  = flg;
    exp_q.delete();
    exp_q.push_back(cw(0, 0, 0, pir_rd, 0, 0, 1, 0, 0, 0, 0, 5, 1));  // FETCH0
    exp_q.push_back(cw(0, 0, 0, pir_rd, 1, 0, 0, 0, 0, 1, 0, 0, 2));  // FETCH1
    exp_pc = pc + 8'd1;
    case (opc)
      4'h2: exp_q.push_back(cw(0, oh, rs, rd, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
        exp_q.push_back(cw(0, 0, rd, rd, 0, 0, 0, 1, 0, 0, 0, 0, 1));
        exp_q.push_back(cw(0, oh, rs, rd, 0, 0, 0, 0, 1, 0, 3'(opc - 4'h3), 0, 0));
      end
      4'h1, 4'h8, 4'h9, 4'hA: begin
        exp_q.push_back(cw(0, 0, 0, rd, 0, 0, 0, 0, 0, 0, 0, 0, 0));  // DECODE
        exp_q.push_back(cw(0, 0, 0, rd, 0, 0, 1, 0, 0, 0, 0, 5, 1));  // OPA
        exp_pc = pc + 8'd2;
        if (opc == 4'h1)
          exp_q.push_back(cw(0, oh, 0, rd, 1, 0, 0, 0, 0, 0, 0, 0, 2));
        else if (opc == 4'h8) begin
          exp_q.push_back(cw(0, 0, 0, rd, 1, 0, 1, 0, 0, 0, 0, 0, 2));
          exp_q.push_back(cw(0, oh, 0, rd, 0, 0, 0, 0, 0, 0, 0, 0, 2));
        end else if (opc == 4'h9 || flg[0]) begin
          exp_q.push_back(cw(0, 0, 0, rd, 0, 1, 0, 0, 0, 0, 0, 0, 2));
          exp_pc = opnd;
        end else
          exp_q.push_back(cw(0, 0, 0, rd, 1, 0, 0, 0, 0, 0, 0, 0, 2));
      end
      4'hF: begin
        exp_q.push_back(cw(0, 0, 0, rd, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 22; i++)
          exp_q.push_back(cw(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      end
      default: exp_q.push_back(cw(0, 0, 0, rd, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endcase
    total = exp_q.size();
    n = 0;
    while (exp_q.size() > 0 && n < max_cyc) begin
      @(negedge clk);
      e = exp_q.pop_front();
      check_word(e, $sformatf("%s c%0d", tag, n));
      if (inc_PC) pc = pc + 8'd1;
      if (load_PC) pc = opnd;
      if (n == 1) begin
        @(posedge clk);
        #1;
        ir_out = op;
      end
      n++;
    end
    exp_q.delete();
    if (n == total) check_pc(exp_pc, {tag, " pc"});
  endtask

  initial begin
    rst    = 1'b1;
    ir_out = 8'h00;
    flags  = 8'h00;
    pc     = 8'h00;
    #2;
    check_word('0, "reset_state");
    @(negedge clk);
    do_reset("reset_init");

    run_instr(8'h12, 8'h5A, 8'($urandom_range(0, 255)), 99, "ldi_r2");
    run_instr(8'h39, 8'h00, 8'($urandom_range(0, 255)), 99, "add_r1_r2");
    run_instr(8'h2C, 8'h00, 8'($urandom_range(0, 255)), 99, "mov_r0_r3");
    run_instr(8'h4A, 8'h00, 8'($urandom_range(0, 255)), 99, "sub_r2_r2");
    run_instr(8'h5B, 8'h00, 8'($urandom_range(0, 255)), 99, "and_r3_r2");
    run_instr(8'h64, 8'h00, 8'($urandom_range(0, 255)), 99, "or_r0_r1");
    run_instr(8'h7D, 8'h00, 8'($urandom_range(0, 255)), 99, "xor_r1_r3");
    run_instr(8'hA0, 8'h40, 8'h01, 99, "jz_taken");
    run_instr(8'hA0, 8'h40, 8'h00, 99, "jz_not_taken");
    run_instr(8'hA0, 8'h40, 8'hFE, 99, "jz_z_clear_hi_set");
    run_instr(8'h90, 8'h10, 8'($urandom_range(0, 255)), 99, "jmp");
    run_instr(8'h83, 8'h20, 8'($urandom_range(0, 255)), 99, "ld_r3");
    run_instr(8'hC0, 8'h00, 8'($urandom_range(0, 255)), 99, "undef_c0");
    run_instr(8'hB2, 8'h00, 8'($urandom_range(0, 255)), 99, "undef_b2");
    run_instr(8'hE1, 8'h00, 8'($urandom_range(0, 255)), 99, "undef_e1");
    run_instr(8'h00, 8'h00, 8'($urandom_range(0, 255)), 99, "nop");

    // abort ADD R1,R2 in EXEC1 (4th cycle)
    run_instr(8'h39, 8'h00, 8'h00, 4, "add_abort");
    do_reset("reset_exec1");
    run_instr(8'h12, 8'h5A, 8'h00, 99, "ldi_after_reset");

    run_instr(8'hF0, 8'h00, 8'($urandom_range(0, 255)), 99, "hlt");
    do_reset("reset_halt");
    run_instr(8'h00, 8'h00, 8'h00, 99, "nop_after_halt");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
